// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: MSB-first shift-out with repeats and idle gaps.
// Optional even-parity bit per repetition when SEQ_GEN_PARITY_EN is defined.
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [7:0]       GAP_L   = 8'(GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
`ifdef SEQ_GEN_PARITY_EN
        S_PARITY,
`endif
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d, sh_d;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, eff_len;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [7:0]       gap_q, gap_d;
    logic             seg_end;
    logic             out_d, valid_d, busy_d, done_d;
`ifdef SEQ_GEN_PARITY_EN
    logic             par_q, par_d;
    logic [WIDTH-1:0] sh_q;
    logic             cur_bit;
`endif

    always_comb begin
        eff_len = len;
        if (len == '0 || len > WIDTH_L) begin
            eff_len = WIDTH_L;
        end
    end

`ifdef SEQ_GEN_PARITY_EN
    always_comb begin
        sh_q    = pat_q >> idx_q;
        cur_bit = sh_q[0];
    end
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        seg_end = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SHIFT;
                    pat_d   = pattern;
                    len_d   = eff_len;
                    rep_d   = repeat_cnt;
                    idx_d   = eff_len - LEN_W'(1);
`ifdef SEQ_GEN_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    par_d = par_q ^ cur_bit;
`endif
                    if (idx_q == '0) begin
`ifdef SEQ_GEN_PARITY_EN
                        state_d = S_PARITY;
`else
                        seg_end = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q - LEN_W'(1);
                    end
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    seg_end = 1'b1;
                end
            end
`endif
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    state_d = S_SHIFT;
                    idx_d   = len_q - LEN_W'(1);
`ifdef SEQ_GEN_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // End of one repetition: gap, back-to-back reload, or finish
        if (seg_end) begin
            if (rep_q != '0) begin
                rep_d = rep_q - REP_W'(1);
                if (GAP_L != 8'd0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_L - 8'd1;
                end else begin
                    state_d = S_SHIFT;
                    idx_d   = len_q - LEN_W'(1);
`ifdef SEQ_GEN_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end else begin
                state_d = S_DONE;
            end
        end
    end

    // Outputs are decoded from the next state so they register with it
    always_comb begin
        sh_d    = pat_d >> idx_d;
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            S_SHIFT: begin
                out_d   = sh_d[0];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: begin
                out_d   = par_d;
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
`endif
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            rep_q     <= rep_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            out       <= out_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef SEQ_GEN_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-pattern transmitter: captures a parallel pattern of programmable length and shifts it out one bit per clock, MSB of the active field first, optionally repeated with idle gaps. It is the stimulus and transmit side of the team's serial sequence-detector FSMs. It drives the detector's single-bit `in` input so that pattern detection can be exercised on-chip and in system benches.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits.
- `LEN_W`, default 4: width of `len`; must satisfy 2^LEN_W > WIDTH.
- `REP_W`, default 4: width of `repeat`.
- `GAP`, default 0: idle cycles inserted between repetitions (0..255).

Ports (one clock, `clk`; reset `reset` is asynchronous and active-high):
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: async active-high reset.
- `start`  input  1: request a transmission; accepted only in IDLE.
- `abort`  input  1: synchronous cancel of a transmission in progress.
- `pattern`  input  WIDTH: bits to send, right-justified.
- `len`  input  LEN_W: number of bits to send.
- `repeat`  input  REP_W: extra repetitions; the pattern is sent `repeat+1` times.
- `out`  output  1: serial data bit; 0 when `out_valid`=0.
- `out_valid`  output  1: `out` carries a pattern or parity bit this cycle.
- `busy`  output  1: high from acceptance through the last bit.
- `done`  output  1: one-cycle pulse after normal completion.

## Operation
- States: IDLE, SHIFT, PARITY (macro only), GAP, DONE.
- Reset: state IDLE. `out`, `out_valid`, `busy` and `done` are all 0. Internal counters are cleared.
- IDLE:
  - `start`=1 and `abort`=0 at a rising edge accepts the request.
  - On acceptance, `pattern`, the effective length, and `repeat` are registered, and the state goes to SHIFT.
  - Later changes on these inputs are ignored until the next acceptance.
- Effective length: `len`=0 or `len`>WIDTH is treated as WIDTH. Otherwise it is `len`.
- SHIFT:
  - Sends bits `pattern[L-1]` down to `pattern[0]`, one per cycle, with `out_valid`=1.
  - After bit 0: go to PARITY if enabled. Otherwise go to GAP if repetitions remain and GAP>0. Otherwise go back to SHIFT for the next repetition if one remains (back-to-back, no idle cycle). Otherwise go to DONE.
- GAP: exactly GAP cycles with `out`=0 and `out_valid`=0, then SHIFT for the next repetition.
- DONE: one cycle with `done`=1 and `busy`=0, then IDLE. `start` is ignored in DONE.
- `busy`=1 in SHIFT, PARITY and GAP.
- `abort`=1 in SHIFT, PARITY or GAP: at the next edge the state goes to IDLE, outputs go to 0, and no `done` pulse is produced.
- `abort`=1 in IDLE or DONE has no effect. `abort` together with `start` in IDLE: abort wins and the request is not accepted.
- `start` while busy is ignored and not queued.

## Timing
- Start is accepted at edge N. The first bit is valid in the cycle after edge N, which gives 1-cycle latency.
- Each bit is held for exactly one cycle.
- `busy` cycles = R·(L+P) + (R−1)·GAP, where R = `repeat`+1, and P = 1 with parity or 0 without.
- `done` rises in the cycle immediately after the last valid bit.
- The earliest next acceptance is at the edge ending the IDLE cycle that follows DONE.
- Reset asserted mid-transmission: outputs go to 0 immediately (asynchronously). No `done` pulse is produced. Transmission resumes only on a new `start`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SEQ_GEN_PARITY_EN` defined:
  - A PARITY state follows each repetition's last bit.
  - It sends one bit, `out` = XOR of the L sent bits (even parity), with `out_valid`=1.
  - It is included in the `busy` count.
- Undefined: the PARITY state and its logic are absent, and P=0.

## Test plan
- `pattern`=8'hA5, `len`=8, `repeat`=0 → `out`=1,0,1,0,0,1,0,1 on 8 consecutive `out_valid` cycles starting one cycle after `start`. `done` is high in the 9th cycle. `busy` is high for exactly 8 cycles.
- `pattern`=8'h05, `len`=3, `repeat`=1, GAP=2 → valid bits 1,0,1, then 2 cycles with `out_valid`=0, then 1,0,1, then `done`. A connected "101" sequence detector flags twice.
- `len`=0 with `pattern`=8'h81 → 8 bits sent (1,0,0,0,0,0,0,1). `len`=12 is treated the same way.
- `abort` raised at the 3rd valid bit of 8'hFF/8 → `out_valid`=0 from the next cycle. `done` stays 0. A following `start` restarts from bit 7.
- `start` pulsed while `busy`, and `start`+`abort` together in IDLE → both ignored, no extra bits.
- With `SEQ_GEN_PARITY_EN`, `pattern`=8'h07, `len`=3 → bits 1,1,1,1 (parity 1), then `done`. Async `reset` mid-parity drives all outputs to 0 the same cycle.
